// File: rtl/shift_seq_ctrl.sv
// Sequences one ARM-style shift (LSL/LSR/ASR/ROR by N) onto an external
// serial shift register: a parallel load, then N single-bit shift cycles.
module shift_seq_ctrl #(
  parameter int unsigned W  = 32,
  parameter int unsigned AW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] amount,
  input  logic [W-1:0]  data_in,
  input  logic          carry_in,
  input  logic [W-1:0]  sr_q,
  output logic          ps,
  output logic          rl,
  output logic          serial_left,
  output logic          serial_right,
  output logic [W-1:0]  sr_data,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          carry_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  state_t        state, state_nxt;
  logic [1:0]    op_r, op_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          carry_nxt;

  // State and operand registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_r      <= 2'b00;
      cnt       <= '0;
      carry_out <= 1'b0;
    end else begin
      state     <= state_nxt;
      op_r      <= op_nxt;
      cnt       <= cnt_nxt;
      carry_out <= carry_nxt;
    end
  end

  // Next state and shift-register controls; the register reloads itself whenever ps=1
  always_comb begin
    state_nxt    = state;
    op_nxt       = op_r;
    cnt_nxt      = cnt;
    carry_nxt    = carry_out;
    ps           = 1'b1;
    rl           = 1'b0;
    serial_left  = 1'b0;
    serial_right = 1'b0;
    sr_data      = sr_q;
    busy         = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          sr_data = data_in;
          op_nxt  = op;
          cnt_nxt = amount;
          if (amount == '0) begin
            carry_nxt = carry_in;
            state_nxt = DONE;
          end else begin
            state_nxt = SHIFT;
          end
        end
      end

      SHIFT: begin
        ps      = 1'b0;
        busy    = 1'b1;
        sr_data = '0;
        cnt_nxt = cnt - AW'(1);
        if (cnt == AW'(1)) state_nxt = DONE;
        case (op_r)
          OP_LSL: begin
            rl           = 1'b0;
            serial_right = 1'b0;
            carry_nxt    = sr_q[W-1];
          end
          OP_LSR: begin
            rl          = 1'b1;
            serial_left = 1'b0;
            carry_nxt   = sr_q[0];
          end
          OP_ASR: begin
            rl          = 1'b1;
            serial_left = sr_q[W-1];
            carry_nxt   = sr_q[0];
          end
          OP_ROR: begin
            rl          = 1'b1;
            serial_left = sr_q[0];
            carry_nxt   = sr_q[0];
          end
          default: ;
        endcase
      end

      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end

      default: state_nxt = IDLE;
    endcase
  end

  assign result = sr_q;

endmodule
